regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port between two requesters: the ALU writeback path and the memory-load writeback path.
- Arbitrates round-robin, registers the winning index and data, and drives the one-hot per-register write strobes.
- Index-to-strobe mapping: code 000 -> bit 7 (r7) ... code 111 -> bit 0 (r0).
- Exports a combinational pending-write mask so the issue logic can detect RAW hazards.

Parameters:
DATA_WIDTH, 16, width of register data on both requester buses and on the write port.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
hold  input  1  register file busy; suppresses new grants while high.
alu_req  input  1  ALU write request; held high until alu_ack is seen.
alu_reg  input  3  ALU destination register code.
alu_data  input  DATA_WIDTH  ALU write data.
alu_ack  output  1  one-cycle grant pulse to the ALU.
mem_req  input  1  load write request; held high until mem_ack is seen.
mem_reg  input  3  load destination register code.
mem_data  input  DATA_WIDTH  load write data.
mem_ack  output  1  one-cycle grant pulse to the load path.
wr_enable  output  8  one-hot register write strobe (bit 7 = r7 = code 000 ... bit 0 = r0 = code 111).
wr_data  output  DATA_WIDTH  data for the strobed register.
pending  output  8  registers with an outstanding, not-yet-acked write request.
last_grant  output  1  0 = ALU granted last, 1 = MEM granted last.

Behaviour:
- Reset (asynchronous, immediate): wr_enable = 0, wr_data = 0, alu_ack = 0, mem_ack = 0, last_grant = 1 (so ALU wins the first tie), state = IDLE.
- States, encoding what was issued on the current cycle:
  - IDLE: no write.
  - WR_ALU: wr_enable, wr_data and alu_ack are driven from the ALU request.
  - WR_MEM: same, from the load request.
- Eligibility each cycle:
  - alu_elig = alu_req & ~alu_ack; mem_elig = mem_req & ~mem_ack.
  - Masking a requester on its own ack cycle prevents a still-high req from being granted twice.
- Next state:
  - hold = 1 -> IDLE.
  - Else only one eligible -> that one.
  - Else both eligible -> the one opposite last_grant.
  - Else IDLE.
- On entry to WR_x (registered, 1-cycle latency from the eligible req):
  - wr_enable = decode(x_reg); wr_data = x_data; x_ack = 1; last_grant updated.
- In IDLE: wr_enable = 0, both acks 0, wr_data holds its last value, last_grant unchanged.
- Throughput:
  - One write per cycle when both requesters are active (alternating).
  - A single requester is limited to one write every 2 cycles because of the ack mask.
- Fairness: a requester waits at most one write cycle while hold is low.
- Same register from both requesters: both writes are issued in round-robin order; the later grant's data is final. No merging or dropping.
- pending is combinational: (alu_req & ~alu_ack ? decode(alu_reg) : 0) | (mem_req & ~mem_ack ? decode(mem_reg) : 0).
- hold asserted while in WR_x: the write already on the outputs completes that cycle; the next state is IDLE.
- Requester index/data are sampled only on the granting edge. Changes while req is high and not yet acked are legal; the latest value wins.
- Reset mid-write: strobes and acks drop immediately. The interrupted write is treated as not performed, and the requester must re-request.
- wr_enable is always 0 or exactly one-hot.

Test Plan:
- Reset, then alu_req=1, alu_reg=000, alu_data=16'h1234 -> next edge: wr_enable=8'b10000000, wr_data=16'h1234, alu_ack=1 for exactly one cycle; pending=8'b10000000 before the ack, 0 after req drops.
- Both reqs rise together (alu_reg=010, mem_reg=111) after reset -> ALU first (wr_enable=8'b00100000), MEM next cycle (8'b00000001), last_grant 0 then 1.
- Both reqs held continuously for 6 cycles with new data each ack -> strict alternation ALU, MEM, ALU...; wr_enable never zero after the first edge; no double ack.
- Only alu_req held high for 4 cycles -> acks on cycles 1 and 3; wr_enable=0 on cycles 2 and 4.
- hold=1 with both reqs pending for 3 cycles -> wr_enable=0, no acks, pending=union of both decodes; hold drops -> grant resumes opposite last_grant.
- reset pulsed mid-cycle during WR_MEM -> wr_enable, mem_ack and alu_ack go 0 without waiting for a clock edge; last_grant=1; first grant after release goes to ALU.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between the ALU writeback
//   path and the memory-load writeback path. Round-robin arbitration with a
//   registered grant: the winning index is decoded to a one-hot strobe
//   (code 000 -> bit 7 / r7 ... code 111 -> bit 0 / r0), the winning data is
//   registered, and a one-cycle ack is returned to the winner.
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-high reset
//   hold        register file busy; no new grants while high
//   alu_req     ALU write request, held until alu_ack
//   alu_reg     ALU destination register code
//   alu_data    ALU write data
//   alu_ack     one-cycle grant pulse to the ALU
//   mem_req     load write request, held until mem_ack
//   mem_reg     load destination register code
//   mem_data    load write data
//   mem_ack     one-cycle grant pulse to the load path
//   wr_enable   one-hot register write strobe (or all zero)
//   wr_data     data for the strobed register
//   pending     registers with an outstanding, not-yet-acked write request
//   last_grant  0 = ALU granted last, 1 = MEM granted last
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  alu_req,
  input  logic [2:0]            alu_reg,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ack,
  input  logic                  mem_req,
  input  logic [2:0]            mem_reg,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_ack,
  output logic [7:0]            wr_enable,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [7:0]            pending,
  output logic                  last_grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_ALU = 2'd1,
    WR_MEM = 2'd2
  } state_t;

  state_t state, next_state;
  logic   alu_elig, mem_elig;

  // Register code 000 maps to the top strobe bit.
  function automatic logic [7:0] decode(input logic [2:0] code);
    logic [7:0] onehot;
    onehot = '0;
    onehot[3'd7 - code] = 1'b1;
    return onehot;
  endfunction

  // State register: the state names the write issued on the current cycle,
  // so the acks fall straight out of it and drop the instant reset rises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and combinational outputs.
  always_comb begin
    alu_ack    = (state == WR_ALU);
    mem_ack    = (state == WR_MEM);
    // A requester on its own ack cycle is still holding req high; masking it
    // keeps the same request from being granted twice.
    alu_elig   = alu_req & ~alu_ack;
    mem_elig   = mem_req & ~mem_ack;
    pending    = (alu_elig ? decode(alu_reg) : '0) |
                 (mem_elig ? decode(mem_reg) : '0);
    next_state = IDLE;
    if (!hold) begin
      if (alu_elig && mem_elig) begin
        next_state = last_grant ? WR_ALU : WR_MEM;
      end else if (alu_elig) begin
        next_state = WR_ALU;
      end else if (mem_elig) begin
        next_state = WR_MEM;
      end
    end
  end

  // Write port registers, loaded on the granting edge only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_enable  <= '0;
      wr_data    <= '0;
      last_grant <= 1'b1;
    end else begin
      unique case (next_state)
        WR_ALU: begin
          wr_enable  <= decode(alu_reg);
          wr_data    <= alu_data;
          last_grant <= 1'b0;
        end
        WR_MEM: begin
          wr_enable  <= decode(mem_reg);
          wr_data    <= mem_data;
          last_grant <= 1'b1;
        end
        default: begin
          wr_enable  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: randomized and directed request
// traffic; a reference model predicts each grant into a queue and a monitor
// pops and compares whenever the DUT acks.
module tb_regfile_write_arbiter;

  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          hold = 1'b0;
  logic          alu_req = 1'b0;
  logic [2:0]    alu_reg = '0;
  logic [DW-1:0] alu_data = '0;
  logic          alu_ack;
  logic          mem_req = 1'b0;
  logic [2:0]    mem_reg = '0;
  logic [DW-1:0] mem_data = '0;
  logic          mem_ack;
  logic [7:0]    wr_enable;
  logic [DW-1:0] wr_data;
  logic [7:0]    pending;
  logic          last_grant;

  regfile_write_arbiter #(.DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .hold(hold),
    .alu_req(alu_req), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ack(alu_ack),
    .mem_req(mem_req), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ack(mem_ack),
    .wr_enable(wr_enable), .wr_data(wr_data), .pending(pending),
    .last_grant(last_grant)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register r(7-code) is written for code; shift a top-bit marker down.
  function automatic logic [7:0] strobe_of(input logic [2:0] code);
    logic [7:0] top;
    top = 8'b1000_0000;
    return top >> code;
  endfunction

  typedef struct {
    logic          from_mem;
    logic [7:0]    strobe;
    logic [DW-1:0] data;
  } grant_t;

  grant_t        sb[$];
  // Model view of what the DUT shows after the coming edge.
  logic          m_last = 1'b1;
  logic          m_alu_ack = 1'b0;
  logic          m_mem_ack = 1'b0;
  logic [DW-1:0] m_data = '0;

  // Reference model: evaluated mid-cycle when inputs are stable; predicts the
  // write that the next rising edge issues.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        m_last = 1'b1; m_alu_ack = 1'b0; m_mem_ack = 1'b0; m_data = '0;
      end else begin
        logic ae, me;
        int   win; // 0 none, 1 alu, 2 mem
        ae = alu_req && !m_alu_ack;
        me = mem_req && !m_mem_ack;
        check("pending", {24'd0, pending},
              {24'd0, (ae ? strobe_of(alu_reg) : 8'h00) | (me ? strobe_of(mem_reg) : 8'h00)});
        win = 0;
        if (!hold) begin
          if (ae && me) win = m_last ? 1 : 2;
          else if (ae)  win = 1;
          else if (me)  win = 2;
        end
        m_alu_ack = (win == 1);
        m_mem_ack = (win == 2);
        if (win == 1) begin
          sb.push_back('{1'b0, strobe_of(alu_reg), alu_data});
          m_last = 1'b0; m_data = alu_data;
        end else if (win == 2) begin
          sb.push_back('{1'b1, strobe_of(mem_reg), mem_data});
          m_last = 1'b1; m_data = mem_data;
        end
      end
    end
  end

  // Monitor: just after each rising edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        check("acks", {30'd0, alu_ack, mem_ack}, {30'd0, m_alu_ack, m_mem_ack});
        check("last_grant", {31'd0, last_grant}, {31'd0, m_last});
        if (alu_ack || mem_ack) begin
          if (sb.size() == 0) begin
            check("unexpected_grant", 32'd1, 32'd0);
          end else begin
            grant_t g;
            g = sb.pop_front();
            check("grant_src", {31'd0, mem_ack}, {31'd0, g.from_mem});
            check("wr_enable", {24'd0, wr_enable}, {24'd0, g.strobe});
            check("wr_data", {16'd0, wr_data}, {16'd0, g.data});
          end
        end else begin
          check("idle_enable", {24'd0, wr_enable}, 32'd0);
          check("idle_data", {16'd0, wr_data}, {16'd0, m_data});
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // One cycle of protocol-following requesters: a req stays high until its
  // ack; want_x re-requests with fresh data right after an ack.
  task automatic drive_cycle(input bit want_alu, input bit want_mem, input bit hold_v);
    hold = hold_v;
    if (alu_req && alu_ack) begin
      alu_req = want_alu;
      if (want_alu) begin alu_reg = 3'($urandom); alu_data = DW'($urandom); end
    end else if (!alu_req) begin
      alu_req = want_alu;
      alu_reg = 3'($urandom); alu_data = DW'($urandom);
    end else if ($urandom_range(3) == 0) begin
      alu_reg = 3'($urandom); alu_data = DW'($urandom);
    end
    if (mem_req && mem_ack) begin
      mem_req = want_mem;
      if (want_mem) begin mem_reg = 3'($urandom); mem_data = DW'($urandom); end
    end else if (!mem_req) begin
      mem_req = want_mem;
      mem_reg = 3'($urandom); mem_data = DW'($urandom);
    end else if ($urandom_range(3) == 0) begin
      mem_reg = 3'($urandom); mem_data = DW'($urandom);
    end
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    alu_req = 1'b0; mem_req = 1'b0; hold = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    step();
    check("rst_enable", {24'd0, wr_enable}, 32'd0);
    check("rst_data", {16'd0, wr_data}, 32'd0);
    check("rst_acks", {30'd0, alu_ack, mem_ack}, 32'd0);
    check("rst_last", {31'd0, last_grant}, 32'd1);
    step();
    reset = 1'b0;

    // Single ALU write to r7.
    alu_req = 1'b1; alu_reg = 3'b000; alu_data = 16'h1234;
    step();
    check("alu1_enable", {24'd0, wr_enable}, 32'h80);
    check("alu1_ack", {31'd0, alu_ack}, 32'd1);
    alu_req = 1'b0;
    step();
    check("alu1_ack_pulse", {31'd0, alu_ack}, 32'd0);
    step();

    // Simultaneous requests after reset: ALU first, then MEM.
    do_reset();
    alu_req = 1'b1; alu_reg = 3'b010; alu_data = 16'haaaa;
    mem_req = 1'b1; mem_reg = 3'b111; mem_data = 16'h5555;
    step();
    check("tie_first", {24'd0, wr_enable}, 32'h20);
    alu_req = 1'b0;
    step();
    check("tie_second", {24'd0, wr_enable}, 32'h01);
    mem_req = 1'b0;
    step();

    // Both held continuously: strict alternation.
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b0, 1'b0);
    // Lone ALU requester: one write every other cycle.
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b0, 1'b0);
    // Hold with both pending, then release.
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      drive_cycle(1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0),
                  1'($urandom_range(7) == 0));
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0);

    // Reset in the middle of a MEM write.
    mem_req = 1'b1; mem_reg = 3'b011; mem_data = 16'hbeef;
    step();
    check("pre_rst_mem_ack", {31'd0, mem_ack}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("midrst_enable", {24'd0, wr_enable}, 32'd0);
    check("midrst_acks", {30'd0, alu_ack, mem_ack}, 32'd0);
    check("midrst_last", {31'd0, last_grant}, 32'd1);
    alu_req = 1'b1; alu_reg = 3'b101; alu_data = 16'h0f0f;
    step();
    reset = 1'b0;
    step();
    check("post_rst_alu_first", {31'd0, alu_ack}, 32'd1);
    alu_req = 1'b0;
    step();
    check("post_rst_mem_second", {31'd0, mem_ack}, 32'd1);
    mem_req = 1'b0;
    step(); step();

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
